// File: rtl/rnn_fixed_pkg.sv
// Shared fixed-point definitions for the RNN gate datapaths: FSM encoding,
// accumulator sizing and Q-format saturation limits.
package rnn_fixed_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } gate_state_t;

  // Full-precision products plus enough guard bits to sum n_terms of them and a bias.
  function automatic int acc_width(input int data_width, input int n_terms);
    return 2 * data_width + $clog2(n_terms + 1) + 1;
  endfunction

  function automatic longint sat_max(input int data_width);
    return (longint'(1) <<< (data_width - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int data_width);
    return -(longint'(1) <<< (data_width - 1));
  endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Drops FRACT_WIDTH fraction bits from a wide accumulator (floor) and clips
// the result into a signed DATA_WIDTH word, flagging when clipping happened.
module fxp_round_sat
  import rnn_fixed_pkg::*;
#(
  parameter int ACC_WIDTH   = 37,
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  output logic signed [DATA_WIDTH-1:0] data,
  output logic                         sat
);

  localparam logic signed [ACC_WIDTH-1:0] MAX_V = ACC_WIDTH'(sat_max(DATA_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] MIN_V = ACC_WIDTH'(sat_min(DATA_WIDTH));

  // Returns {sat, data}.
  function automatic logic [DATA_WIDTH:0] shift_sat(input logic signed [ACC_WIDTH-1:0] a);
    logic signed [ACC_WIDTH-1:0] s;
    s = a >>> FRACT_WIDTH;
    if (s > MAX_V)
      shift_sat = {1'b1, MAX_V[DATA_WIDTH-1:0]};
    else if (s < MIN_V)
      shift_sat = {1'b1, MIN_V[DATA_WIDTH-1:0]};
    else
      shift_sat = {1'b0, s[DATA_WIDTH-1:0]};
  endfunction

  assign {sat, data} = shift_sat(acc);

endmodule

// File: rtl/gate_mac_seq.sv
// Sequential multiply-accumulate for one RNN gate pre-activation:
// W*{x,h} + b over N_IN+N_HID streamed operand/weight pairs, saturated to DATA_WIDTH.
module gate_mac_seq
  import rnn_fixed_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8,
  parameter int N_IN        = 4,
  parameter int N_HID       = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] bias,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic signed [DATA_WIDTH-1:0] in_weight,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_sat,
  output logic                         busy
);

  localparam int N_PAIRS   = N_IN + N_HID;
  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, N_PAIRS);
  localparam int CNT_W     = $clog2(N_PAIRS + 1);

  gate_state_t                   state, state_nxt;
  logic        [CNT_W-1:0]       cnt;
  logic signed [2*DATA_WIDTH-1:0] prod_p1;
  logic                          vld_p1;
  logic signed [ACC_WIDTH-1:0]   acc_p2;
  logic signed [ACC_WIDTH-1:0]   prod_ext;
  logic signed [ACC_WIDTH-1:0]   acc_sum;
  logic signed [ACC_WIDTH-1:0]   bias_ext;
  logic signed [DATA_WIDTH-1:0]  sat_data;
  logic                          sat_flag;
  logic                          accept;
  logic                          last_pair;

  assign accept    = in_valid && in_ready;
  assign last_pair = accept && (cnt == CNT_W'(N_PAIRS - 1));
  assign prod_ext  = ACC_WIDTH'(prod_p1);
  assign acc_sum   = vld_p1 ? (acc_p2 + prod_ext) : acc_p2;
  assign bias_ext  = ACC_WIDTH'(bias) <<< FRACT_WIDTH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (last_pair) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // p1: register the full-precision product of each accepted pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (accept) prod_p1 <= in_data * in_weight;
    end
  end

  // p2: accumulate, then shift/saturate into the output register during DRAIN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p2   <= '0;
      cnt      <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc_p2 <= bias_ext;
            cnt    <= '0;
          end
        end
        ACCUM: begin
          acc_p2 <= acc_sum;
          if (accept) cnt <= cnt + 1'b1;
        end
        DRAIN: begin
          acc_p2   <= acc_sum;
          out_data <= sat_data;
          out_sat  <= sat_flag;
        end
        default: ;
      endcase
    end
  end

  fxp_round_sat #(
    .ACC_WIDTH  (ACC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .FRACT_WIDTH(FRACT_WIDTH)
  ) u_round_sat (
    .acc (acc_sum),
    .data(sat_data),
    .sat (sat_flag)
  );

endmodule

// File: tb/tb_gate_mac_seq.sv
// Scoreboard bench for gate_mac_seq in a 2+2 pair configuration, Q8.8 operands.
module tb_gate_mac_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] bias = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [15:0] in_weight = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_sat;
  logic        busy;

  gate_mac_seq #(
    .DATA_WIDTH (16),
    .FRACT_WIDTH(8),
    .N_IN       (2),
    .N_HID      (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bias     (bias),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_weight(in_weight),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        s;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] pd[4];
  logic [15:0] pw[4];
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: exact integer sum, floor shift, clip.
  function automatic logic [16:0] model(input logic [15:0] b);
    longint a, s;
    a = longint'($signed(b)) * 256;
    for (int i = 0; i < 4; i++)
      a += longint'($signed(pd[i])) * longint'($signed(pw[i]));
    s = a >>> 8;
    if (s > 32767)  return {1'b1, 16'h7fff};
    if (s < -32768) return {1'b1, 16'h8000};
    return {1'b0, s[15:0]};
  endfunction

  task automatic set_pairs(input logic [15:0] d0, input logic [15:0] w0,
                           input logic [15:0] d, input logic [15:0] w);
    pd[0] = d0; pw[0] = w0;
    for (int i = 1; i < 4; i++) begin pd[i] = d; pw[i] = w; end
  endtask

  task automatic run_eval(input string name, input logic [15:0] b,
                          input logic [15:0] ed, input logic es,
                          input int gap, input int ordly, input int pulse, input int exp_lat);
    exp_t        e;
    int          cyc, idx, wait_n, lat;
    bit          seen, done, unstable, acc_now;
    logic [15:0] hd;
    logic        hs;
    sb.push_back('{ed, es});
    @(posedge clk); #1;
    start = 1'b1; bias = b; in_valid = 1'b0;
    idx = 0; cyc = 0; wait_n = 0; lat = 0; hd = '0; hs = 1'b0;
    seen = 0; done = 0; unstable = 0;
    while (!done && cyc < 300) begin
      acc_now = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc_now) idx++;
      start = (pulse != 0) && (cyc % 3 == 0);
      if (out_ready) begin
        out_ready = 1'b0;
        start = 1'b0;
        done = 1;
      end else if (out_valid) begin
        if (!seen) begin
          seen = 1; lat = cyc; hd = out_data; hs = out_sat;
        end else if (out_data !== hd || out_sat !== hs) unstable = 1;
        if (wait_n >= ordly) begin
          out_ready = 1'b1;
          start = 1'b1;
        end else wait_n++;
      end
      in_valid = (idx < 4) && (gap == 0 || cyc % 2 == 0);
      if (idx < 4) begin in_data = pd[idx]; in_weight = pw[idx]; end
    end
    check_val({name, ":completed"}, longint'(done), 1);
    e = sb.pop_front();
    check_val({name, ":data"}, longint'(hd), longint'(e.d));
    check_val({name, ":sat"}, longint'(hs), longint'(e.s));
    check_val({name, ":idle_after_handshake"}, longint'(busy), 0);
    check_val({name, ":valid_dropped"}, longint'(out_valid), 0);
    if (exp_lat > 0) check_val({name, ":latency"}, longint'(lat), longint'(exp_lat));
    if (ordly > 0) check_val({name, ":stable_while_stalled"}, longint'(unstable), 0);
  endtask

  initial begin
    logic [16:0] m;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst:out_valid", longint'(out_valid), 0);
    check_val("rst:in_ready", longint'(in_ready), 0);
    check_val("rst:busy", longint'(busy), 0);
    check_val("rst:out_data", longint'(out_data), 0);
    check_val("rst:out_sat", longint'(out_sat), 0);
    rst_n = 1'b1;

    set_pairs(16'h0100, 16'h0080, 16'h0100, 16'h0080);
    run_eval("basic", 16'h0040, 16'h0240, 1'b0, 0, 0, 0, 6);

    set_pairs(16'hff00, 16'h0100, 16'hff00, 16'h0100);
    run_eval("neg", 16'h0000, 16'hfc00, 1'b0, 0, 0, 0, 6);

    set_pairs(16'hffff, 16'h0001, 16'h0000, 16'h0000);
    run_eval("floor", 16'h0000, 16'hffff, 1'b0, 0, 0, 0, 0);

    set_pairs(16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff);
    run_eval("sat_pos", 16'h7fff, 16'h7fff, 1'b1, 0, 0, 0, 0);

    set_pairs(16'h8000, 16'h7fff, 16'h8000, 16'h7fff);
    run_eval("sat_neg", 16'h0000, 16'h8000, 1'b1, 0, 0, 0, 0);

    set_pairs(16'h0100, 16'h0080, 16'h0100, 16'h0080);
    run_eval("stall", 16'h0040, 16'h0240, 1'b0, 1, 5, 1, 0);

    for (int r = 0; r < 3; r++) begin
      logic [15:0] rb;
      for (int i = 0; i < 4; i++) begin
        pd[i] = 16'($urandom_range(0, 65535));
        pw[i] = 16'($urandom_range(0, 65535));
      end
      if (r == 0) for (int i = 0; i < 4; i++) pw[i] = 16'($urandom_range(0, 511)) - 16'd256;
      rb = 16'($urandom_range(0, 65535));
      m = model(rb);
      run_eval($sformatf("rand%0d", r), rb, m[15:0], m[16], r % 2, r, r % 2, 0);
    end

    // Abort an evaluation after two accepted pairs.
    set_pairs(16'h0100, 16'h0080, 16'h0100, 16'h0080);
    set_pairs(16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff);
    run_eval("pre_abort", 16'h7fff, 16'h7fff, 1'b1, 0, 0, 0, 0);
    set_pairs(16'h0100, 16'h0080, 16'h0100, 16'h0080);
    @(posedge clk); #1;
    start = 1'b1; bias = 16'h0040;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = pd[0]; in_weight = pw[0];
    @(posedge clk); #1;
    in_data = pd[1]; in_weight = pw[1];
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    check_val("abort:out_valid", longint'(out_valid), 0);
    check_val("abort:in_ready", longint'(in_ready), 0);
    check_val("abort:busy", longint'(busy), 0);
    check_val("abort:out_data", longint'(out_data), 0);
    check_val("abort:out_sat", longint'(out_sat), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_eval("after_abort", 16'h0040, 16'h0240, 1'b0, 0, 0, 0, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gate_mac_seq.md
GATE_MAC_SEQ -- requirements
Module: gate_mac_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 16, signed two's-complement operand/result width.
REQ-002 Parameter FRACT_WIDTH, default 8, fractional bits of every operand, bias and result.
REQ-003 Parameter N_IN, default 4, number of input-vector (x) elements per gate evaluation.
REQ-004 Parameter N_HID, default 4, number of hidden-state (h) elements per gate evaluation.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  begin a new evaluation; honoured only in IDLE.
REQ-008 bias  input  DATA_WIDTH  signed gate bias; sampled when start is honoured.
REQ-009 in_valid  input  1  operand/weight pair present.
REQ-010 in_ready  output  1  block accepts a pair this cycle.
REQ-011 in_data  input  DATA_WIDTH  signed x or h element; x elements first, then h elements.
REQ-012 in_weight  input  DATA_WIDTH  signed weight paired with in_data.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  consumer takes result.
REQ-015 out_data  output  DATA_WIDTH  signed saturated pre-activation W*{x,h}+b.
REQ-016 out_sat  output  1  out_data was clipped at a saturation limit.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, ACCUM, DRAIN and DONE.
REQ-019 IDLE: in_ready=0, out_valid=0; start=1 loads acc = bias sign-extended and shifted left FRACT_WIDTH, clears count and product-valid flag, goes to ACCUM.
REQ-020 ACCUM: in_ready=1; a pair is accepted when in_valid&&in_ready; each accepted pair's full 2*DATA_WIDTH product SHALL be registered the next cycle and added to acc the cycle after that (one-stage product pipeline).
REQ-021 in_valid gaps SHALL stall counting without corrupting acc; products already registered are still added.
REQ-022 Acceptance of pair number N_IN+N_HID SHALL move to DRAIN; in_ready=0 from DRAIN onward.
REQ-023 DRAIN (exactly one cycle): final product added; out_data/out_sat registered from (acc+last product) and state goes to DONE.
REQ-024 Accumulator width ACC_WIDTH = 2*DATA_WIDTH + clog2(N_IN+N_HID+1) + 1; no intermediate overflow is possible.
REQ-025 Result = acc arithmetically shifted right FRACT_WIDTH (truncation toward minus infinity), then clipped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; out_sat=1 exactly when clipping occurred.
REQ-026 DONE: out_valid=1; out_data/out_sat held stable until out_valid&&out_ready, then IDLE.
REQ-027 start outside IDLE SHALL be ignored; start in the DONE handshake cycle SHALL be ignored (new evaluation requires IDLE).
REQ-028 Unstalled latency: start at cycle T -> out_valid at T+N_IN+N_HID+2.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, acc=0, count=0, product register and flag cleared, out_data=0, out_sat=0, out_valid=0, in_ready=0, busy=0, including mid-evaluation; partial results are discarded.

Structure
REQ-030 Package rnn_fixed_pkg SHALL hold the state encoding, ACC_WIDTH derivation function and the Q-format saturation limits, shared with other gate blocks.
REQ-031 Shift-and-saturate SHALL be a sub-module fxp_round_sat (ACC_WIDTH in, DATA_WIDTH out plus sat flag), reusable by other gate units.

Verification (DATA_WIDTH=16, FRACT_WIDTH=8, N_IN=2, N_HID=2)
REQ-032 Four pairs 0x0100*0x0080, bias 0x0040, continuous valid -> out_data 0x0240, out_sat 0, out_valid at T+6.
REQ-033 Four pairs 0xFF00*0x0100, bias 0x0000 -> out_data 0xFC00; one pair 0xFFFF*0x0001, rest 0 -> 0xFFFF (floor), out_sat 0.
REQ-034 Four pairs 0x7FFF*0x7FFF, bias 0x7FFF -> 0x7FFF, out_sat 1; four pairs 0x8000*0x7FFF -> 0x8000, out_sat 1.
REQ-035 in_valid toggled every other cycle, out_ready low 5 cycles -> result same as REQ-032, out_data stable while stalled, start pulses during busy ignored.
REQ-036 rst_n asserted after 2 accepted pairs -> all outputs 0 immediately; fresh REQ-032 run then yields 0x0240.
